// File: rtl/ysyx22041405_ifu_if.sv
// ----------------------------------------------------------------------------
// ysyx22041405_ifu_if
//   Bundles every handshake/bus signal of the instruction fetch unit:
//   the instruction-memory request/response channel, the EXU redirect
//   input and the IF->ID output channel.
//
//   Handshake rule for both valid/ready pairs (imem_req_* and
//   if_valid/id_ready): a transfer happens on a rising clock edge where
//   valid and ready are both 1; once valid is raised, the sender holds
//   valid and its payload stable until that transfer (or a redirect).
//   imem_rsp_valid and redirect_valid are single-cycle strobes with no ready.
//
//   master : the IFU side
//   slave  : the environment side (memory, EXU, IDU)
// ----------------------------------------------------------------------------
interface ysyx22041405_ifu_if #(
   parameter int WIDTH = 32
);
   logic               imem_req_valid;
   logic               imem_req_ready;
   logic [WIDTH-1:0]   imem_addr;
   logic               imem_rsp_valid;
   logic [WIDTH-1:0]   imem_rsp_data;
   logic               imem_rsp_err;
   logic               redirect_valid;
   logic [WIDTH-1:0]   redirect_pc;
   logic [2*WIDTH-1:0] IF_ID_message;
   logic               if_valid;
   logic               id_ready;

   modport master (
      output imem_req_valid, imem_addr, IF_ID_message, if_valid,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
             redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  imem_req_valid, imem_addr, IF_ID_message, if_valid,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
             redirect_valid, redirect_pc, id_ready
   );
endinterface

// File: rtl/ysyx22041405_ifu.sv
// ----------------------------------------------------------------------------
// ysyx22041405_ifu
//   Instruction fetch unit. Owns the PC, issues one instruction-memory
//   request at a time, and hands {pc, inst} to the IDU through a
//   one-entry output register. EXU redirects reload the PC and squash any
//   fetch that is still in flight.
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous, active-low reset
//   bus       : ysyx22041405_ifu_if.master (imem req/rsp, redirect, IF->ID)
//   inst_cnt  : number of instructions accepted by the IDU (wraps)
//   state_dbg : current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 OUT)
// ----------------------------------------------------------------------------
module ysyx22041405_ifu #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h8000_0000)
) (
   input  logic                      clk,
   input  logic                      rst,
   ysyx22041405_ifu_if.master        bus,
   output logic [31:0]               inst_cnt,
   output logic [1:0]                state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      OUT  = 2'd3
   } state_t;

   // Delivered on a fetch fault so the IDU traps at the faulting pc.
   localparam logic [WIDTH-1:0] EBREAK = WIDTH'(32'h0010_0073);

   state_t           state, state_n;
   logic [WIDTH-1:0] pc, pc_n;
   logic [WIDTH-1:0] out_inst, out_inst_n;
   logic             drop, drop_n;
   logic [31:0]      cnt_n;
   logic [WIDTH-1:0] redirect_aligned;

   assign redirect_aligned = {bus.redirect_pc[WIDTH-1:2], 2'b00};

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         drop     <= 1'b0;
         out_inst <= '0;
         inst_cnt <= '0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         drop     <= drop_n;
         out_inst <= out_inst_n;
         inst_cnt <= cnt_n;
      end
   end

   // ----------------------------------------------------- next-state logic
   // redirect_valid wins over every other event in every state.
   always_comb begin
      state_n    = state;
      pc_n       = pc;
      drop_n     = drop;
      out_inst_n = out_inst;
      cnt_n      = inst_cnt;

      case (state)
         IDLE: begin
            state_n = REQ;
            if (bus.redirect_valid) pc_n = redirect_aligned;
         end

         REQ: begin
            if (bus.redirect_valid) begin
               pc_n = redirect_aligned;
               if (bus.imem_req_ready) begin
                  // The request already went out with the old pc; its
                  // response must be thrown away.
                  drop_n  = 1'b1;
                  state_n = WAIT;
               end
            end else if (bus.imem_req_ready) begin
               state_n = WAIT;
            end
         end

         WAIT: begin
            if (bus.redirect_valid) begin
               pc_n = redirect_aligned;
               if (bus.imem_rsp_valid) begin
                  // Response for the stale pc lands right now: consume it
                  // and go straight back to fetching.
                  drop_n  = 1'b0;
                  state_n = REQ;
               end else begin
                  drop_n  = 1'b1;
               end
            end else if (bus.imem_rsp_valid) begin
               if (drop) begin
                  drop_n  = 1'b0;
                  state_n = REQ;
               end else begin
                  out_inst_n = bus.imem_rsp_err ? EBREAK : bus.imem_rsp_data;
                  state_n    = OUT;
               end
            end
         end

         OUT: begin
            if (bus.redirect_valid) begin
               // Held instruction is on the wrong path: not counted.
               pc_n    = redirect_aligned;
               state_n = REQ;
            end else if (bus.id_ready) begin
               pc_n    = pc + WIDTH'(4);
               cnt_n   = inst_cnt + 32'd1;
               state_n = REQ;
            end
         end

         default: state_n = IDLE;
      endcase
   end

   // --------------------------------------------------------------- outputs
   assign bus.imem_req_valid = (state == REQ);
   assign bus.imem_addr      = pc;
   assign bus.if_valid       = (state == OUT);
   // pc is frozen while in OUT, so {pc, out_inst} is the fetched pair.
   assign bus.IF_ID_message  = (state == OUT) ? {pc, out_inst} : '0;
   assign state_dbg          = state;

endmodule

// File: tb/tb_ysyx22041405_ifu.sv
// ----------------------------------------------------------------------------
// tb_ysyx22041405_ifu
//   Directed bench for the fetch unit. Inputs change on the falling edge;
//   outputs are checked on the falling edge, half a cycle after the rising
//   edge that produced them.
// ----------------------------------------------------------------------------
module tb_ysyx22041405_ifu;

  localparam int W = 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic        clk;
  logic        rst;
  logic [31:0] inst_cnt;
  logic [1:0]  state_dbg;

  int tests_run;
  int tests_failed;

  ysyx22041405_ifu_if #(.WIDTH(W)) bus ();

  ysyx22041405_ifu #(.WIDTH(W), .RESET_PC(32'h8000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .inst_cnt  (inst_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------- clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------- driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"},     64'(state_dbg),          64'(S_IDLE));
    chk({tag, "_req_valid"}, 64'(bus.imem_req_valid), 64'd0);
    chk({tag, "_if_valid"},  64'(bus.if_valid),       64'd0);
    chk({tag, "_msg"},       bus.IF_ID_message,       64'd0);
    chk({tag, "_cnt"},       64'(inst_cnt),           64'd0);
    chk({tag, "_addr"},      64'(bus.imem_addr),      64'h8000_0000);
  endtask

  // Respond in WAIT: present one response for the coming edge.
  task automatic respond(input logic [31:0] data, input logic err);
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = data;
    bus.imem_rsp_err   = err;
    step();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_err   = 1'b0;
    bus.imem_rsp_data  = 32'h0;
  endtask

  // ---------------------------------------------------------- stimulus
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst                = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.imem_rsp_err   = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b1;

    // ---- reset values
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    step();                                       // IDLE -> REQ

    // ---- 1: basic fetch
    chk("t1_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("t1_addr",      64'(bus.imem_addr),      64'h8000_0000);
    step();                                       // REQ -> WAIT
    chk("t1_wait",      64'(state_dbg),          64'(S_WAIT));
    chk("t1_no_req",    64'(bus.imem_req_valid), 64'd0);
    respond(32'h0000_0413, 1'b0);                 // WAIT -> OUT
    chk("t1_if_valid",  64'(bus.if_valid),       64'd1);
    chk("t1_msg",       bus.IF_ID_message,       64'h8000_0000_0000_0413);
    step();                                       // OUT -> REQ (id_ready=1)
    chk("t1_next_addr", 64'(bus.imem_addr),      64'h8000_0004);
    chk("t1_next_req",  64'(bus.imem_req_valid), 64'd1);
    chk("t1_cnt",       64'(inst_cnt),           64'd1);

    // ---- 2: IDU back-pressure for 5 cycles
    bus.id_ready = 1'b0;
    step();                                       // -> WAIT
    respond(32'h0000_0513, 1'b0);                 // -> OUT
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 64'(bus.if_valid),       64'd1);
      chk("t2_hold_msg",   bus.IF_ID_message,       64'h8000_0004_0000_0513);
      chk("t2_hold_noreq", 64'(bus.imem_req_valid), 64'd0);
      step();
    end
    chk("t2_cnt_held",  64'(inst_cnt),           64'd1);
    bus.id_ready = 1'b1;
    step();
    chk("t2_next_addr", 64'(bus.imem_addr),      64'h8000_0008);
    chk("t2_cnt",       64'(inst_cnt),           64'd2);

    // ---- 5: fetch fault delivers EBREAK with the faulting pc
    step();                                       // -> WAIT
    bus.id_ready = 1'b0;
    respond(32'h1234_5678, 1'b1);                 // -> OUT
    chk("t5_msg",       bus.IF_ID_message,       64'h8000_0008_0010_0073);
    bus.id_ready = 1'b1;
    step();
    chk("t5_next_addr", 64'(bus.imem_addr),      64'h8000_000C);
    chk("t5_cnt",       64'(inst_cnt),           64'd3);

    // ---- 3: redirect while WAIT, late response dropped
    step();                                       // -> WAIT
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    step();                                       // stay WAIT, drop=1
    bus.redirect_valid = 1'b0;
    chk("t3_still_wait", 64'(state_dbg),         64'(S_WAIT));
    chk("t3_addr_upd",   64'(bus.imem_addr),     64'h8000_0100);
    step();                                       // nothing arrives yet
    chk("t3_no_valid_a", 64'(bus.if_valid),      64'd0);
    respond(32'hDEAD_BEEF, 1'b0);                 // dropped -> REQ
    chk("t3_no_valid_b", 64'(bus.if_valid),      64'd0);
    chk("t3_req",        64'(bus.imem_req_valid), 64'd1);
    chk("t3_addr",       64'(bus.imem_addr),     64'h8000_0100);
    chk("t3_cnt",        64'(inst_cnt),          64'd3);

    // ---- 4: redirect while OUT with id_ready=1, misaligned target
    step();                                       // -> WAIT
    respond(32'h0000_0613, 1'b0);                 // -> OUT
    chk("t4_msg",        bus.IF_ID_message,      64'h8000_0100_0000_0613);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0203;
    step();
    bus.redirect_valid = 1'b0;
    chk("t4_addr",       64'(bus.imem_addr),     64'h8000_0200);
    chk("t4_cnt",        64'(inst_cnt),          64'd3);
    chk("t4_state",      64'(state_dbg),         64'(S_REQ));

    // ---- redirect in REQ without req_ready: address moves, stay REQ
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0300;
    step();
    chk("rq_state",      64'(state_dbg),         64'(S_REQ));
    chk("rq_addr",       64'(bus.imem_addr),     64'h8000_0300);
    // ---- redirect in REQ with req_ready: old request in flight, dropped
    bus.imem_req_ready = 1'b1;
    bus.redirect_pc    = 32'h8000_0400;
    step();
    bus.redirect_valid = 1'b0;
    chk("rr_state",      64'(state_dbg),         64'(S_WAIT));
    respond(32'h0BAD_0BAD, 1'b0);                 // dropped -> REQ
    chk("rr_no_valid",   64'(bus.if_valid),      64'd0);
    chk("rr_addr",       64'(bus.imem_addr),     64'h8000_0400);

    // ---- 6: reset during WAIT, stale response after release
    step();                                       // -> WAIT
    chk("t6_wait",       64'(state_dbg),         64'(S_WAIT));
    rst = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    @(negedge clk);
    rst = 1'b1;
    bus.imem_rsp_valid = 1'b1;                    // stale response in IDLE
    bus.imem_rsp_data  = 32'hFFFF_FFFF;
    step();                                       // IDLE -> REQ
    bus.imem_rsp_valid = 1'b0;
    chk("t6_restart_req", 64'(bus.imem_req_valid), 64'd1);
    chk("t6_restart_addr",64'(bus.imem_addr),     64'h8000_0000);
    chk("t6_if_valid",    64'(bus.if_valid),      64'd0);
    chk("t6_cnt",         64'(inst_cnt),          64'd0);

    // ---- pc wrap at 0xFFFF_FFFC
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    chk("wrap_addr_hi",  64'(bus.imem_addr),     64'hFFFF_FFFC);
    step();                                       // -> WAIT
    respond(32'h0000_0013, 1'b0);                 // -> OUT
    chk("wrap_msg",      bus.IF_ID_message,      64'hFFFF_FFFC_0000_0013);
    step();
    chk("wrap_addr_lo",  64'(bus.imem_addr),     64'h0000_0000);
    chk("wrap_cnt",      64'(inst_cnt),          64'd1);

    // ---- final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
